// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Receive side of the PWM link. Measures an incoming PWM waveform and reports
// its high time, its period and its duty cycle as a 7-bit code on the same
// 0..SCALE scale that the PWM generator takes on its duty input.
//
// Data path:
//   pwm_in -> 2-flop synchroniser (s_sync) -> delay flop (s_prev) -> edge detect
//   edge detect -> saturating cycle counter -> capture registers
//   capture registers -> 7-iteration restoring divider -> result registers
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   pwm_in      PWM waveform, may be asynchronous to clk
//   duty        last measured duty code, floor(high_len*SCALE/period_len)
//   high_len    last captured high time, in clk cycles
//   period_len  last captured period, in clk cycles
//   valid       one-cycle pulse when duty/high_len/period_len update
//   busy        high while the divider runs
//   stuck_hi    pwm_in stayed high for TIMEOUT cycles without an edge
//   stuck_lo    pwm_in stayed low for TIMEOUT cycles without an edge
//
// Parameters:
//   CNT_W    width of the high-time and period counters
//   SCALE    full-scale duty code, at most 127
//   TIMEOUT  cycles without a rise before a stuck condition, < 2**CNT_W
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int SCALE   = 100,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [6:0]       duty,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] period_len,
  output logic             valid,
  output logic             busy,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  // Divider width: the dividend hi_cap*SCALE needs CNT_W+7 bits because
  // SCALE fits in 7 bits.
  localparam int unsigned DW = CNT_W + 7;

  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [6:0]       SCL    = 7'(SCALE);
  localparam logic [2:0]       LAST_I = 3'd6;

  typedef enum logic {
    S_IDLE,
    S_DIV
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detector
  // ---------------------------------------------------------------------------
  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_rise;
  logic w_fall;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours; blocking here would
  // collapse the synchroniser chain into a single flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= pwm_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign w_rise = r_sync & ~r_prev;
  assign w_fall = ~r_sync & r_prev;

  // ---------------------------------------------------------------------------
  // Cycle counter and high-time capture
  // ---------------------------------------------------------------------------
  // The counter is loaded with 1 on the first high cycle, so on the following
  // fall it holds the number of high cycles and on the following rise it holds
  // the period. It parks at TMO, which is what the timeout logic watches.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_cap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi_cap <= '0;
    end else begin
      if (w_rise) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != TMO) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_fall) begin
        r_hi_cap <= r_cnt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_iter;
  logic       r_armed;
  logic       r_stuck_hi;
  logic       r_stuck_lo;
  logic       w_start;
  logic       w_div_done;
  logic       w_timeout;
  logic       w_busy;

  // A rise starts a divide only when a full period lies behind it (armed),
  // the divider is free, and the period did not saturate: a saturated
  // period is a timeout, never a measurement.
  assign w_start = w_rise & r_armed & (r_state == S_IDLE) & (r_cnt != TMO);

  assign w_div_done = (r_state == S_DIV) && (r_iter == LAST_I);

  // A timeout that coincides with a divide completion is held off; the
  // counter stays parked at TMO, so it fires on the very next cycle. Rise
  // cycles are excluded because the counter restarts there.
  assign w_timeout = (r_cnt == TMO) && !r_stuck_hi && !r_stuck_lo &&
                     !w_rise && !w_div_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal written in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a
  // latch.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_DIV;
        end
      end
      S_DIV: begin
        w_busy = 1'b1;
        if (w_div_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // armed means the counter currently times a complete period: set by any
  // rise, cleared by a timeout so that the first rise afterwards only
  // restarts timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (w_rise) begin
      r_armed <= 1'b1;
    end else if (w_timeout) begin
      r_armed <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring divider: duty = floor(hi_cap*SCALE / period)
  // ---------------------------------------------------------------------------
  // The quotient never exceeds SCALE (< 128), so dividend < divisor*128 and
  // seven trial subtractions of divisor<<6 .. divisor<<0 give the full
  // quotient, MSB first. Operands are latched at start so edges arriving
  // during the divide cannot disturb the running result.
  logic [DW-1:0]    r_rem;
  logic [DW-1:0]    r_dvs;
  logic [6:0]       r_quo;
  logic [CNT_W-1:0] r_hi_op;
  logic [CNT_W-1:0] r_per_op;
  logic [DW-1:0]    w_dividend;
  logic             w_ge;
  logic [DW-1:0]    w_rem_next;
  logic [6:0]       w_quo_next;

  assign w_dividend = {7'd0, r_hi_cap} * DW'(SCALE);
  assign w_ge       = (r_rem >= r_dvs);
  assign w_rem_next = w_ge ? (r_rem - r_dvs) : r_rem;
  assign w_quo_next = {r_quo[5:0], w_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem    <= '0;
      r_dvs    <= '0;
      r_quo    <= '0;
      r_iter   <= '0;
      r_hi_op  <= '0;
      r_per_op <= '0;
    end else if (w_start) begin
      r_rem    <= w_dividend;
      r_dvs    <= {7'd0, r_cnt} << 6;
      r_quo    <= '0;
      r_iter   <= '0;
      r_hi_op  <= r_hi_cap;
      r_per_op <= r_cnt;
    end else if (r_state == S_DIV) begin
      r_rem  <= w_rem_next;
      r_dvs  <= r_dvs >> 1;
      r_quo  <= w_quo_next;
      r_iter <= r_iter + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers and stuck flags
  // ---------------------------------------------------------------------------
  logic [6:0]       r_duty;
  logic [CNT_W-1:0] r_high_len;
  logic [CNT_W-1:0] r_period_len;
  logic             r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_duty       <= '0;
      r_high_len   <= '0;
      r_period_len <= '0;
      r_valid      <= 1'b0;
      r_stuck_hi   <= 1'b0;
      r_stuck_lo   <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (w_div_done) begin
        // The last quotient bit is still combinational this cycle.
        r_duty       <= w_quo_next;
        r_high_len   <= r_hi_op;
        r_period_len <= r_per_op;
        r_valid      <= 1'b1;
      end else if (w_timeout) begin
        r_valid      <= 1'b1;
        r_period_len <= TMO;
        if (r_sync) begin
          r_stuck_hi <= 1'b1;
          r_duty     <= SCL;
          r_high_len <= TMO;
        end else begin
          r_stuck_lo <= 1'b1;
          r_duty     <= '0;
          r_high_len <= '0;
        end
      end

      // Any rise proves the line is toggling again.
      if (w_rise) begin
        r_stuck_hi <= 1'b0;
        r_stuck_lo <= 1'b0;
      end
    end
  end

  assign duty       = r_duty;
  assign high_len   = r_high_len;
  assign period_len = r_period_len;
  assign valid      = r_valid;
  assign busy       = w_busy;
  assign stuck_hi   = r_stuck_hi;
  assign stuck_lo   = r_stuck_lo;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//
// Directed bench for pwm_capture. A table of {high, period, periods, expected}
// records covers the steady-state measurement; hand-written sequences cover
// result latency, stuck-high/low timeouts, reset during a divide and a duty
// change between periods. A monitor logs every valid pulse with its cycle
// number so both values and timing can be compared.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int SCALE   = 100;
  localparam int TIMEOUT = 1023;

  logic             clk    = 1'b0;
  logic             reset  = 1'b1;
  logic             pwm_in = 1'b0;
  logic [6:0]       duty;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] period_len;
  logic             valid;
  logic             busy;
  logic             stuck_hi;
  logic             stuck_lo;

  pwm_capture #(
    .CNT_W  (CNT_W),
    .SCALE  (SCALE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .high_len  (high_len),
    .period_len(period_len),
    .valid     (valid),
    .busy      (busy),
    .stuck_hi  (stuck_hi),
    .stuck_lo  (stuck_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int duty;
    int hi;
    int per;
    int shi;
    int slo;
  } rep_t;

  typedef struct {
    int h;
    int p;
    int n;
    int stride;
    int exp_reps;
    int exp_duty;
  } vec_t;

  rep_t reps[$];
  int   rises[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Cycle counter plus valid-pulse logger, sampling 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (valid === 1'b1) begin
        reps.push_back('{cyc, int'(duty), int'(high_len), int'(period_len),
                         int'(stuck_hi), int'(stuck_lo)});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rep(input string tag, input int idx, input int e_duty, input int e_hi,
                           input int e_per, input int e_cyc, input int e_shi, input int e_slo);
    if (idx < reps.size()) begin
      check($sformatf("%s[%0d] duty", tag, idx), reps[idx].duty, e_duty);
      check($sformatf("%s[%0d] high_len", tag, idx), reps[idx].hi, e_hi);
      check($sformatf("%s[%0d] period_len", tag, idx), reps[idx].per, e_per);
      check($sformatf("%s[%0d] valid cycle", tag, idx), reps[idx].cyc, e_cyc);
      check($sformatf("%s[%0d] stuck_hi", tag, idx), reps[idx].shi, e_shi);
      check($sformatf("%s[%0d] stuck_lo", tag, idx), reps[idx].slo, e_slo);
    end else begin
      check($sformatf("%s[%0d] report present", tag, idx), reps.size(), idx + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset duty", 32'(duty), 0);
    check("reset high_len", 32'(high_len), 0);
    check("reset period_len", 32'(period_len), 0);
    check("reset valid", 32'(valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset stuck_hi", 32'(stuck_hi), 0);
    check("reset stuck_lo", 32'(stuck_lo), 0);
    reset = 1'b0;
    reps.delete();
    rises.delete();
    idle(3);
  endtask

  // n periods of h high cycles then p-h low cycles, driven on falling edges.
  task automatic run_pwm(input int h, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        pwm_in = (c < h);
        if (c == 0) rises.push_back(cyc);
      end
    end
  endtask

  vec_t vecs[9];
  int   d;

  initial begin
    // {high, period, periods, report stride, reports, expected duty}
    vecs = '{
      '{30,  100, 3, 1, 2, 30},
      '{1,   9,   6, 1, 5, 11},
      '{8,   9,   4, 1, 3, 88},
      '{7,   20,  4, 1, 3, 35},
      '{2,   5,   7, 2, 3, 40},
      '{33,  64,  3, 1, 2, 51},
      '{99,  100, 3, 1, 2, 99},
      '{1,   127, 3, 1, 2, 0},
      '{126, 127, 3, 1, 2, 99}
    };

    // ---- Table-driven steady-state measurement ----
    // A rise driven at cycle d is detected at d+2 and reported at d+10; the
    // first rise after reset only arms, so report j belongs to rise stride*j+1.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      run_pwm(vecs[i].h, vecs[i].p, vecs[i].n);
      idle(20);
      check($sformatf("vec%0d report count", i), reps.size(), vecs[i].exp_reps);
      for (int j = 0; j < vecs[i].exp_reps; j++) begin
        check_rep($sformatf("vec%0d", i), j, vecs[i].exp_duty, vecs[i].h, vecs[i].p,
                  rises[vecs[i].stride * j + 1] + 10, 0, 0);
      end
    end

    // ---- Result latency: busy for E+1..E+7, valid alone in E+8 ----
    do_reset();
    run_pwm(30, 100, 2);
    @(negedge clk);
    pwm_in = 1'b1;
    d = cyc;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency busy @d+%0d", k), 32'(busy), 32'((k >= 3) && (k <= 9)));
      check($sformatf("latency valid @d+%0d", k), 32'(valid), 32'(k == 10));
    end
    check("latency duty", 32'(duty), 30);
    @(negedge clk);
    pwm_in = 1'b0;
    idle(10);

    // ---- Stuck high ----
    do_reset();
    run_pwm(30, 100, 2);
    @(negedge clk);
    pwm_in = 1'b1;
    d = cyc;
    idle(TIMEOUT + 10);
    check("stuck_hi report count", reps.size(), 3);
    check_rep("stuck_hi pre", 1, 30, 30, 100, d + 10, 0, 0);
    check_rep("stuck_hi", 2, SCALE, TIMEOUT, TIMEOUT, d + TIMEOUT + 3, 1, 0);
    check("stuck_hi level", 32'(stuck_hi), 1);
    @(negedge clk);
    pwm_in = 1'b0;
    idle(20);
    check("stuck_hi held after fall", 32'(stuck_hi), 1);
    check("stuck_hi no extra valid", reps.size(), 3);
    reps.delete();
    rises.delete();
    run_pwm(30, 100, 3);
    idle(20);
    check("stuck_hi cleared", 32'(stuck_hi), 0);
    check("stuck_hi rearm count", reps.size(), 2);
    check_rep("stuck_hi rearm", 0, 30, 30, 100, rises[1] + 10, 0, 0);
    check_rep("stuck_hi rearm", 1, 30, 30, 100, rises[2] + 10, 0, 0);

    // ---- Stuck low ----
    do_reset();
    run_pwm(30, 100, 2);
    d = rises[1];
    idle(TIMEOUT + 10);
    check("stuck_lo report count", reps.size(), 2);
    check_rep("stuck_lo", 1, 0, 0, TIMEOUT, d + TIMEOUT + 3, 0, 1);
    check("stuck_lo level", 32'(stuck_lo), 1);
    reps.delete();
    rises.delete();
    run_pwm(30, 100, 3);
    idle(20);
    check("stuck_lo cleared", 32'(stuck_lo), 0);
    check("stuck_lo rearm count", reps.size(), 2);
    check_rep("stuck_lo rearm", 0, 30, 30, 100, rises[1] + 10, 0, 0);

    // ---- Reset asserted during the divide (cycle E+4) ----
    do_reset();
    run_pwm(50, 100, 2);
    @(negedge clk);
    pwm_in = 1'b1;
    idle(6);
    check("mid-div busy", 32'(busy), 1);
    check("mid-div duty before reset", 32'(duty), 50);
    reset = 1'b1;
    reps.delete();
    #1;
    check("mid-div reset duty", 32'(duty), 0);
    check("mid-div reset high_len", 32'(high_len), 0);
    check("mid-div reset period_len", 32'(period_len), 0);
    check("mid-div reset busy", 32'(busy), 0);
    check("mid-div reset valid", 32'(valid), 0);
    idle(2);
    reset  = 1'b0;
    pwm_in = 1'b0;
    rises.delete();
    idle(20);
    check("mid-div no valid after reset", reps.size(), 0);
    run_pwm(50, 100, 3);
    idle(20);
    check("post-reset report count", reps.size(), 2);
    check_rep("post-reset", 0, 50, 50, 100, rises[1] + 10, 0, 0);

    // ---- Duty change 25 -> 75 between periods ----
    do_reset();
    run_pwm(25, 100, 2);
    run_pwm(75, 100, 2);
    idle(20);
    check("duty change count", reps.size(), 3);
    check_rep("duty change", 0, 25, 25, 100, rises[1] + 10, 0, 0);
    check_rep("duty change", 1, 25, 25, 100, rises[2] + 10, 0, 0);
    check_rep("duty change", 2, 75, 75, 100, rises[3] + 10, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
